issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
Unified reservation station between decode/rename and the functional units of the out-of-order core. It accepts decoded micro-ops that carry source tags and readiness bits, and holds them until both operands are produced. Operand wakeup comes from the common data bus (CDB) tag broadcast. Each cycle it issues at most one ALU op and one LSU op, oldest-ready first.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
TAG_W, 6, physical-register/ROB tag width
PAY_W, 64, opaque payload width (opcode, funct3, funct7, imm, dest tag, control bits)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (misprediction); synchronous
disp_valid  in  1  decode offers a micro-op
disp_ready  out  1  scheduler can accept
disp_fu  in  1  FU class: 0=ALU (R/I/branch), 1=LSU (load/store)
disp_src1_tag  in  TAG_W  tag of operand 1
disp_src1_rdy  in  1  operand 1 already available
disp_src2_tag  in  TAG_W  tag of operand 2
disp_src2_rdy  in  1  operand 2 already available
disp_payload  in  PAY_W  carried unchanged to issue
wb_valid  in  1  CDB broadcast valid
wb_tag  in  TAG_W  CDB broadcast tag
alu_issue_valid  out  1  ALU op offered
alu_issue_ready  in  1  ALU accepts
alu_issue_payload  out  PAY_W  selected ALU payload
lsu_issue_valid  out  1  LSU op offered
lsu_issue_ready  in  1  LSU accepts
lsu_issue_payload  out  PAY_W  selected LSU payload
occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Entry state: valid, fu, src1_tag/rdy, src2_tag/rdy, payload. Age matrix older[i][j] (DEPTH x DEPTH).
- Reset (rstn=0, async): all valid=0, age matrix=0, occupancy=0, both issue_valid=0, both payloads=0. disp_ready=1 once rstn=1.
- disp_ready = (occupancy < DEPTH) && !flush. It is computed from registered occupancy only and never depends on same-cycle issue.
- Dispatch fires on disp_valid && disp_ready.
  - The op is written at that edge into the lowest-index free entry.
  - On allocating entry i, older[i][j] = valid[j] for all j.
- Wakeup: on wb_valid, every valid entry whose srcN_tag == wb_tag sets srcN_rdy=1 at the edge.
- Same-cycle bypass: if a dispatching op's disp_srcN_tag == wb_tag while wb_valid, the op is stored with srcN_rdy=1.
- An entry is eligible when valid && src1_rdy && src2_rdy.
- Select, done per class: grant the eligible entry i of that class for which no eligible same-class j has older[i][j]=1. The result is one-hot or zero.
- issue_valid and issue_payload are combinational from registered state. Payload is 0 when issue_valid=0.
- Issue fires on issue_valid && issue_ready. The granted entry's valid is cleared at that edge. ALU and LSU may both issue in the same cycle.
- No stability rule on issue outputs: selection may change while ready=0, e.g. when an older op wakes. The FU samples only on the handshake.
- Latency: an op dispatched with both operands ready at edge N is offered in cycle N+1. An op woken at edge N is offered in cycle N+1.
- occupancy_next = occupancy + dispatch_fire - alu_fire - lsu_fire.
- Simultaneous dispatch and issue:
  - dispatch never reuses an entry freed in the same cycle;
  - a full queue stays unable to accept for that cycle.
- Wakeup with no matching valid entry: no effect. Wakeup and issue of the same entry in one cycle: issue wins, entry freed.
- Flush (highest priority): at the edge all valid=0 and occupancy=0. The same-cycle dispatch is dropped.
  - While flush=1, disp_ready=0 and both issue_valid=0, so no handshake can fire.
- rstn asserted mid-operation: immediate clear, identical to reset values.

Decomposition:
- Package sched_pkg holds:
  - FU_ALU=1'b0 and FU_LSU=1'b1;
  - the entry struct typedef (valid, fu, tags, rdy bits, payload);
  - the occupancy width function.
- Sub-module oldest_ready_select: inputs are the eligible vector and the age matrix; output is a one-hot grant. It is instantiated twice, once for ALU and once for LSU eligible masks.

Test Plan:
1. Reset, then dispatch ALU op (src1_rdy=1, src2_rdy=1, payload=0xA5) with alu_issue_ready=1 -> alu_issue_valid=1 with payload 0xA5 the cycle after dispatch; occupancy 1->0.
2. Dispatch A (src1_tag=5, not ready) then B (both ready), both ALU -> B issues first. Then wb_valid with wb_tag=5 -> A offered the next cycle.
3. Dispatch both ready: ALU X, LSU Y, ALU Z, LSU W, with both FU ready=1 -> X and Y issue in one cycle, then Z and W.
4. Fill 8 entries with src tag 9 not ready -> disp_ready=0 and occupancy=8. Broadcast tag 9 -> one entry per cycle drains; disp_ready returns 1 after the first issue edge.
5. Dispatch with disp_src2_tag=12 not ready while wb_valid with wb_tag=12 in the same cycle -> op offered the next cycle (bypass).
6. Occupancy 5 with flush=1 and disp_valid=1 -> occupancy 0, no issue, and the dispatched op is absent afterwards.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the issue scheduler.
//   FU_ALU / FU_LSU : functional-unit class encoding carried with each micro-op
//   entry_t         : one reservation-station slot
//   occ_w()         : width of an occupancy counter able to hold 0..depth
package sched_pkg;

    localparam logic FU_ALU = 1'b0;
    localparam logic FU_LSU = 1'b1;

    // Entry field widths. The top-level TAG_W / PAY_W parameters default to
    // these and must stay equal to them, since the entry struct is sized here.
    localparam int SCHED_TAG_W = 6;
    localparam int SCHED_PAY_W = 64;

    typedef struct packed {
        logic                   valid;
        logic                   fu;
        logic [SCHED_TAG_W-1:0] src1_tag;
        logic                   src1_rdy;
        logic [SCHED_TAG_W-1:0] src2_tag;
        logic                   src2_rdy;
        logic [SCHED_PAY_W-1:0] payload;
    } entry_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/oldest_ready_select.sv
// Oldest-ready picker over an age matrix.
//   elig_i  : entries that may issue this cycle (already filtered by FU class)
//   older_i : older_i[i][j] = 1 when entry j was allocated before entry i
//   grant_o : one-hot (or zero) grant of the oldest eligible entry
module oldest_ready_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            elig_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
    output logic [DEPTH-1:0]            grant_o
);

    // An entry wins when no other eligible entry is older than it. The age
    // matrix is a strict total order over live entries, so at most one wins.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = elig_i[i] && ((older_i[i] & elig_i) == '0);
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Unified reservation station: holds renamed micro-ops until both source
// operands are available (via dispatch readiness, CDB wakeup or same-cycle
// bypass) and issues at most one ALU and one LSU op per cycle, oldest first.
//   clk, rstn            : clock, asynchronous active-low reset
//   flush                : synchronous pipeline flush, clears every entry
//   disp_*               : dispatch handshake and micro-op fields
//   wb_valid, wb_tag     : CDB tag broadcast
//   alu_issue_*          : ALU issue handshake and payload
//   lsu_issue_*          : LSU issue handshake and payload
//   occupancy            : number of valid entries (registered)
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = SCHED_TAG_W,
    parameter int PAY_W = SCHED_PAY_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   disp_fu,
    input  logic [TAG_W-1:0]       disp_src1_tag,
    input  logic                   disp_src1_rdy,
    input  logic [TAG_W-1:0]       disp_src2_tag,
    input  logic                   disp_src2_rdy,
    input  logic [PAY_W-1:0]       disp_payload,
    input  logic                   wb_valid,
    input  logic [TAG_W-1:0]       wb_tag,
    output logic                   alu_issue_valid,
    input  logic                   alu_issue_ready,
    output logic [PAY_W-1:0]       alu_issue_payload,
    output logic                   lsu_issue_valid,
    input  logic                   lsu_issue_ready,
    output logic [PAY_W-1:0]       lsu_issue_payload,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int OCC_W = occ_w(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);

    entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic   [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    logic   [OCC_W-1:0]            occ_q, occ_d;

    logic [DEPTH-1:0] valid_vec, alu_elig, lsu_elig, alu_gnt, lsu_gnt;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             disp_fire, alu_fire, lsu_fire;
    logic [PAY_W-1:0] alu_pay, lsu_pay;

    always_comb begin
        valid_vec = '0;
        alu_elig  = '0;
        lsu_elig  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            alu_elig[i]  = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy
                           && (ent_q[i].fu == FU_ALU);
            lsu_elig[i]  = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy
                           && (ent_q[i].fu == FU_LSU);
        end
    end

    oldest_ready_select #(.DEPTH(DEPTH)) u_alu_sel (
        .elig_i (alu_elig),
        .older_i(age_q),
        .grant_o(alu_gnt)
    );

    oldest_ready_select #(.DEPTH(DEPTH)) u_lsu_sel (
        .elig_i (lsu_elig),
        .older_i(age_q),
        .grant_o(lsu_gnt)
    );

    // Grants are one-hot, so OR-reduction acts as the payload mux.
    always_comb begin
        alu_pay = '0;
        lsu_pay = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_gnt[i]) alu_pay = alu_pay | ent_q[i].payload;
            if (lsu_gnt[i]) lsu_pay = lsu_pay | ent_q[i].payload;
        end
    end

    assign alu_issue_valid   = (alu_gnt != '0) && !flush;
    assign lsu_issue_valid   = (lsu_gnt != '0) && !flush;
    assign alu_issue_payload = alu_issue_valid ? alu_pay : '0;
    assign lsu_issue_payload = lsu_issue_valid ? lsu_pay : '0;
    assign alu_fire          = alu_issue_valid && alu_issue_ready;
    assign lsu_fire          = lsu_issue_valid && lsu_issue_ready;

    // Free slot search uses registered valid bits only, so a slot released by
    // an issue this cycle is never handed to a dispatch in the same cycle.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !ent_q[i].valid) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign disp_ready = (occ_q < OCC_W'(DEPTH)) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign occupancy  = occ_q;

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && ent_q[i].valid) begin
                if (ent_q[i].src1_tag == wb_tag) ent_d[i].src1_rdy = 1'b1;
                if (ent_q[i].src2_tag == wb_tag) ent_d[i].src2_rdy = 1'b1;
            end
            // Issue beats a same-cycle wakeup of the same entry.
            if ((alu_fire && alu_gnt[i]) || (lsu_fire && lsu_gnt[i]))
                ent_d[i].valid = 1'b0;
        end

        if (disp_fire && free_found) begin
            ent_d[free_idx].valid    = 1'b1;
            ent_d[free_idx].fu       = disp_fu;
            ent_d[free_idx].src1_tag = disp_src1_tag;
            ent_d[free_idx].src1_rdy = disp_src1_rdy || (wb_valid && disp_src1_tag == wb_tag);
            ent_d[free_idx].src2_tag = disp_src2_tag;
            ent_d[free_idx].src2_rdy = disp_src2_rdy || (wb_valid && disp_src2_tag == wb_tag);
            ent_d[free_idx].payload  = disp_payload;
            // New entry is younger than every live one. Its column is cleared
            // so stale bits from the slot's previous tenant cannot make it
            // look older than anything.
            age_d[free_idx] = valid_vec;
            for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = 1'b0;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
        end
    end

    assign occ_d = flush ? '0
                 : occ_q + OCC_W'(disp_fire) - OCC_W'(alu_fire) - OCC_W'(lsu_fire);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_q <= '0;
            age_q <= '0;
            occ_q <= '0;
        end else begin
            ent_q <= ent_d;
            age_q <= age_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: table of single-op dispatch
// vectors plus hand-written multi-cycle sequences. Issued payloads are
// checked against per-class scoreboards filled when stimulus is driven.
module tb_issue_scheduler;
    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int PAY_W = 64;

    logic             clk, rstn, flush;
    logic             disp_valid, disp_ready, disp_fu;
    logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, wb_tag;
    logic             disp_src1_rdy, disp_src2_rdy, wb_valid;
    logic [PAY_W-1:0] disp_payload, alu_issue_payload, lsu_issue_payload;
    logic             alu_issue_valid, alu_issue_ready, lsu_issue_valid, lsu_issue_ready;
    logic [3:0]       occupancy;

    issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .disp_payload(disp_payload), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .alu_issue_valid(alu_issue_valid), .alu_issue_ready(alu_issue_ready),
        .alu_issue_payload(alu_issue_payload),
        .lsu_issue_valid(lsu_issue_valid), .lsu_issue_ready(lsu_issue_ready),
        .lsu_issue_payload(lsu_issue_payload), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [PAY_W-1:0] alu_q[$];
    logic [PAY_W-1:0] lsu_q[$];

    typedef struct {
        logic             fu;
        logic             r1;
        logic [TAG_W-1:0] t1;
        logic             r2;
        logic [TAG_W-1:0] t2;
        logic             wbv;
        logic [TAG_W-1:0] wbt;
        logic [PAY_W-1:0] pay;
        logic             exp_alu;
        logic             exp_lsu;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [PAY_W-1:0] got, input logic [PAY_W-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fu, input logic r1, input logic [TAG_W-1:0] t1,
                         input logic r2, input logic [TAG_W-1:0] t2, input logic [PAY_W-1:0] pay);
        disp_valid = 1'b1; disp_fu = fu;
        disp_src1_rdy = r1; disp_src1_tag = t1;
        disp_src2_rdy = r2; disp_src2_tag = t2;
        disp_payload = pay;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
        #1;
    endtask

    // Scoreboard: every observed handshake must match the oldest expected op.
    always @(negedge clk) begin
        if (rstn) begin
            if (alu_issue_valid && alu_issue_ready) begin
                if (alu_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL alu_unexpected_issue: got=%0h expected=none @%0t", alu_issue_payload, $time);
                end else chk("alu_issue_payload", alu_issue_payload, alu_q.pop_front());
            end
            if (lsu_issue_valid && lsu_issue_ready) begin
                if (lsu_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL lsu_unexpected_issue: got=%0h expected=none @%0t", lsu_issue_payload, $time);
                end else chk("lsu_issue_payload", lsu_issue_payload, lsu_q.pop_front());
            end
            if (!alu_issue_valid) chk("alu_idle_payload", alu_issue_payload, '0);
            if (!lsu_issue_valid) chk("lsu_idle_payload", lsu_issue_payload, '0);
        end
    end

    initial begin
        //            fu    r1   t1  r2   t2  wbv  wbt  pay     alu  lsu
        vecs[0] = '{1'b0, 1'b1, 1, 1'b1, 2, 1'b0, 0, 64'hA5,   1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1, 1'b1, 2, 1'b0, 0, 64'h1234, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 3, 1'b1, 2, 1'b0, 0, 64'h3333, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1, 1'b0, 12, 1'b1, 12, 64'hC0C0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 7, 1'b0, 7, 1'b1, 7, 64'h7777,  1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 7, 1'b1, 2, 1'b1, 8, 64'h5555,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1, 1'b0, 20, 1'b0, 20, 64'h6666, 1'b0, 1'b0};

        rstn = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_tag = '0;
        alu_issue_ready = 1'b1; lsu_issue_ready = 1'b1;
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'hFFFF);
        repeat (3) tick();
        chk("reset_occupancy", 64'(occupancy), 0);
        chk("reset_alu_valid", 64'(alu_issue_valid), 0);
        chk("reset_lsu_valid", 64'(lsu_issue_valid), 0);
        chk("reset_alu_payload", alu_issue_payload, 0);
        chk("reset_lsu_payload", lsu_issue_payload, 0);
        idle();
        tick();
        rstn = 1'b1;
        #1;
        chk("reset_disp_ready", 64'(disp_ready), 1);

        // Single-op table: readiness, bypass and class routing.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].fu, vecs[v].r1, vecs[v].t1, vecs[v].r2, vecs[v].t2, vecs[v].pay);
            wb_valid = vecs[v].wbv; wb_tag = vecs[v].wbt;
            if (vecs[v].exp_alu) alu_q.push_back(vecs[v].pay);
            if (vecs[v].exp_lsu) lsu_q.push_back(vecs[v].pay);
            tick();
            idle();
            chk($sformatf("v%0d_alu_valid", v), 64'(alu_issue_valid), 64'(vecs[v].exp_alu));
            chk($sformatf("v%0d_lsu_valid", v), 64'(lsu_issue_valid), 64'(vecs[v].exp_lsu));
            chk($sformatf("v%0d_alu_payload", v), alu_issue_payload, vecs[v].exp_alu ? vecs[v].pay : 64'h0);
            chk($sformatf("v%0d_lsu_payload", v), lsu_issue_payload, vecs[v].exp_lsu ? vecs[v].pay : 64'h0);
            chk($sformatf("v%0d_occ_after_disp", v), 64'(occupancy), 1);
            tick();
            chk($sformatf("v%0d_occ_after_issue", v), 64'(occupancy),
                (vecs[v].exp_alu || vecs[v].exp_lsu) ? 64'h0 : 64'h1);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            #1;
            chk($sformatf("v%0d_occ_after_flush", v), 64'(occupancy), 0);
        end

        // Younger ready op bypasses an older waiting one; wakeup then frees it.
        drive(1'b0, 1'b0, 5, 1'b1, 2, 64'hA0);
        tick();
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'hB0);
        alu_q.push_back(64'hB0);
        tick();
        idle();
        chk("s2_b_first", alu_issue_payload, 64'hB0);
        tick();
        chk("s2_a_waits", 64'(alu_issue_valid), 0);
        chk("s2_occ", 64'(occupancy), 1);
        wb_valid = 1'b1; wb_tag = 5;
        alu_q.push_back(64'hA0);
        tick();
        idle();
        chk("s2_a_woken", alu_issue_payload, 64'hA0);
        tick();
        chk("s2_occ_empty", 64'(occupancy), 0);

        // Dual issue: one ALU and one LSU in the same cycle, oldest each.
        alu_issue_ready = 1'b0; lsu_issue_ready = 1'b0;
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'h11); tick();
        drive(1'b1, 1'b1, 1, 1'b1, 2, 64'h22); tick();
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'h33); tick();
        drive(1'b1, 1'b1, 1, 1'b1, 2, 64'h44); tick();
        idle();
        alu_q.push_back(64'h11); alu_q.push_back(64'h33);
        lsu_q.push_back(64'h22); lsu_q.push_back(64'h44);
        chk("s3_alu_x", alu_issue_payload, 64'h11);
        chk("s3_lsu_y", lsu_issue_payload, 64'h22);
        alu_issue_ready = 1'b1; lsu_issue_ready = 1'b1;
        tick();
        chk("s3_occ_dual", 64'(occupancy), 2);
        chk("s3_alu_z", alu_issue_payload, 64'h33);
        chk("s3_lsu_w", lsu_issue_payload, 64'h44);
        tick();
        chk("s3_occ_empty", 64'(occupancy), 0);

        // Fill to capacity, reject an extra dispatch, then drain via wakeup.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b0, 9, 1'b1, 2, 64'h400 + 64'(k));
            alu_q.push_back(64'h400 + 64'(k));
            tick();
        end
        idle();
        chk("s4_full_ready", 64'(disp_ready), 0);
        chk("s4_full_occ", 64'(occupancy), 8);
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'hBAD);
        tick();
        idle();
        chk("s4_reject_occ", 64'(occupancy), 8);
        wb_valid = 1'b1; wb_tag = 9;
        tick();
        idle();
        chk("s4_oldest_first", alu_issue_payload, 64'h400);
        chk("s4_ready_while_full", 64'(disp_ready), 0);
        tick();
        chk("s4_ready_after_issue", 64'(disp_ready), 1);
        chk("s4_occ_after_issue", 64'(occupancy), 7);
        for (int k = 0; k < 20 && alu_q.size() > 0; k++) tick();
        chk("s4_drain_done", 64'(alu_q.size()), 0);
        chk("s4_occ_empty", 64'(occupancy), 0);

        // Flush with five pending ops and a dispatch in the same cycle.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 30, 1'b1, 2, 64'h600 + 64'(k));
            tick();
        end
        idle();
        chk("s6_occ5", 64'(occupancy), 5);
        flush = 1'b1;
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'hDEAD);
        #1;
        chk("s6_flush_disp_ready", 64'(disp_ready), 0);
        chk("s6_flush_alu_valid", 64'(alu_issue_valid), 0);
        tick();
        flush = 1'b0;
        idle();
        chk("s6_occ_after_flush", 64'(occupancy), 0);
        chk("s6_dropped_disp", 64'(alu_issue_valid), 0);
        wb_valid = 1'b1; wb_tag = 30;
        tick();
        idle();
        chk("s6_no_ghost_wakeup", 64'(alu_issue_valid), 0);
        chk("s6_occ_still0", 64'(occupancy), 0);

        // Asynchronous reset in mid-operation.
        alu_issue_ready = 1'b0;
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'h71); tick();
        drive(1'b0, 1'b1, 1, 1'b1, 2, 64'h72); tick();
        idle();
        chk("s7_occ_before", 64'(occupancy), 2);
        chk("s7_valid_before", 64'(alu_issue_valid), 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("s7_async_occ", 64'(occupancy), 0);
        chk("s7_async_valid", 64'(alu_issue_valid), 0);
        chk("s7_async_payload", alu_issue_payload, 0);
        tick();
        rstn = 1'b1;
        alu_issue_ready = 1'b1;
        tick();
        chk("s7_post_occ", 64'(occupancy), 0);
        chk("s7_post_valid", 64'(alu_issue_valid), 0);

        chk("final_alu_queue", 64'(alu_q.size()), 0);
        chk("final_lsu_queue", 64'(lsu_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
